// File: rtl/pipe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl_pkg
//  Description : Shared types and constants for the 5-stage pipeline
//                sequencer and the stage registers it controls.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipe_ctrl_pkg;

    // Architectural zero register; never a real hazard source.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // RUN: normal sequencing. DRAIN: redirect held until the ibus is idle.
    typedef enum logic [0:0] {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } ctrl_state_t;

    // Per-stage control bundle, so stage registers can take a single port.
    typedef struct packed {
        logic pc_en;
        logic pc_sel_redirect;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_en;
        logic id_ex_bubble;
        logic ex_mem_en;
        logic mem_wb_en;
        logic mem_wb_bubble;
    } pipe_ctrl_t;

endpackage : pipe_ctrl_pkg
`default_nettype wire

// File: rtl/pipe_ctrl_hazard_detect.sv
`default_nettype none
// ============================================================================
//  Module      : hazard_detect
//  Description : Combinational load-use hazard check between the load in
//                execute and the source operands of the instruction in decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  logic       id_valid,
    input  logic [4:0] id_rs1,
    input  logic [4:0] id_rs2,
    input  logic       id_uses_rs1,
    input  logic       id_uses_rs2,
    input  logic       ex_valid,
    input  logic       ex_is_load,
    input  logic [4:0] ex_rd,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_ex_writes;

    // A load targeting x0 writes nothing, so it can never create a hazard.
    always_comb begin
        w_ex_writes = ex_valid & ex_is_load & (ex_rd != REG_ZERO);
        w_rs1_hit   = id_uses_rs1 & (id_rs1 == ex_rd);
        w_rs2_hit   = id_uses_rs2 & (id_rs2 == ex_rd);
        load_use    = w_ex_writes & id_valid & (w_rs1_hit | w_rs2_hit);
    end

endmodule : hazard_detect
`default_nettype wire

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_ctrl
//  Description : Central sequencer for the 5-stage core. Produces stage
//                enables, bubbles and flushes from bus busy, load-use hazards
//                and execute-stage redirects; holds a redirect across an
//                outstanding fetch; counts stall cycles and applied flushes.
//  Revision    : 1.0 - initial release
// ============================================================================
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             if_busy,
    input  logic             mem_busy,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic             ex_valid,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             pc_en,
    output logic             pc_sel_redirect,
    output logic [XLEN-1:0]  pc_target,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_en,
    output logic             id_ex_bubble,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             mem_wb_bubble,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_count
);

    ctrl_state_t      state_q, state_d;
    logic [XLEN-1:0]  held_q, held_d;
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;
    logic [CNT_W-1:0] flush_count_q, flush_count_d;

    pipe_ctrl_t       w_ctrl;
    logic [XLEN-1:0]  w_pc_target;
    logic             w_flush_inc;
    logic             w_load_use;

    hazard_detect u_hazard (
        .id_valid    (id_valid),
        .id_rs1      (id_rs1),
        .id_rs2      (id_rs2),
        .id_uses_rs1 (id_uses_rs1),
        .id_uses_rs2 (id_uses_rs2),
        .ex_valid    (ex_valid),
        .ex_is_load  (ex_is_load),
        .ex_rd       (ex_rd),
        .load_use    (w_load_use)
    );

    // Next-state and stage control decode, in priority order:
    // reset, mem_busy freeze, DRAIN replay, redirect, load-use, fetch wait.
    always_comb begin
        w_ctrl      = '0;
        w_pc_target = redirect_pc;
        w_flush_inc = 1'b0;
        state_d     = state_q;
        held_d      = held_q;

        if (reset) begin
            w_ctrl.if_id_flush   = 1'b1;
            w_ctrl.id_ex_bubble  = 1'b1;
            w_ctrl.mem_wb_bubble = 1'b1;
            w_pc_target          = '0;
            state_d              = RUN;
            held_d               = '0;
        end else if (mem_busy) begin
            // Everything up to EX/MEM holds; EX re-presents any redirect later.
            w_ctrl.mem_wb_en     = 1'b1;
            w_ctrl.mem_wb_bubble = 1'b1;
            if (state_q == DRAIN) begin
                w_pc_target = held_q;
            end
        end else if (state_q == DRAIN) begin
            // Discard whatever the outstanding fetch returns.
            w_pc_target          = held_q;
            w_ctrl.if_id_en      = 1'b1;
            w_ctrl.if_id_flush   = 1'b1;
            w_ctrl.id_ex_en      = 1'b1;
            w_ctrl.ex_mem_en     = 1'b1;
            w_ctrl.mem_wb_en     = 1'b1;
            if (!if_busy) begin
                w_ctrl.pc_en           = 1'b1;
                w_ctrl.pc_sel_redirect = 1'b1;
                w_flush_inc            = 1'b1;
                state_d                = RUN;
            end
        end else if (redirect_valid) begin
            w_ctrl.if_id_en      = 1'b1;
            w_ctrl.if_id_flush   = 1'b1;
            w_ctrl.id_ex_en      = 1'b1;
            w_ctrl.id_ex_bubble  = 1'b1;
            w_ctrl.ex_mem_en     = 1'b1;
            w_ctrl.mem_wb_en     = 1'b1;
            if (!if_busy) begin
                w_ctrl.pc_en           = 1'b1;
                w_ctrl.pc_sel_redirect = 1'b1;
                w_flush_inc            = 1'b1;
            end else begin
                // PC cannot move while a fetch is in flight; replay later.
                held_d  = redirect_pc;
                state_d = DRAIN;
            end
        end else if (w_load_use) begin
            w_ctrl.id_ex_en      = 1'b1;
            w_ctrl.id_ex_bubble  = 1'b1;
            w_ctrl.ex_mem_en     = 1'b1;
            w_ctrl.mem_wb_en     = 1'b1;
        end else if (if_busy) begin
            w_ctrl.if_id_en      = 1'b1;
            w_ctrl.if_id_flush   = 1'b1;
            w_ctrl.id_ex_en      = 1'b1;
            w_ctrl.ex_mem_en     = 1'b1;
            w_ctrl.mem_wb_en     = 1'b1;
        end else begin
            w_ctrl.pc_en         = 1'b1;
            w_ctrl.if_id_en      = 1'b1;
            w_ctrl.id_ex_en      = 1'b1;
            w_ctrl.ex_mem_en     = 1'b1;
            w_ctrl.mem_wb_en     = 1'b1;
        end

        // Counters wrap naturally at 2^CNT_W.
        stall_cycles_d = stall_cycles_q + CNT_W'(!w_ctrl.pc_en);
        flush_count_d  = flush_count_q + CNT_W'(w_flush_inc);
    end

    // State, held redirect target and performance counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= RUN;
            held_q         <= '0;
            stall_cycles_q <= '0;
            flush_count_q  <= '0;
        end else begin
            state_q        <= state_d;
            held_q         <= held_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign pc_en           = w_ctrl.pc_en;
    assign pc_sel_redirect = w_ctrl.pc_sel_redirect;
    assign pc_target       = w_pc_target;
    assign if_id_en        = w_ctrl.if_id_en;
    assign if_id_flush     = w_ctrl.if_id_flush;
    assign id_ex_en        = w_ctrl.id_ex_en;
    assign id_ex_bubble    = w_ctrl.id_ex_bubble;
    assign ex_mem_en       = w_ctrl.ex_mem_en;
    assign mem_wb_en       = w_ctrl.mem_wb_en;
    assign mem_wb_bubble   = w_ctrl.mem_wb_bubble;
    assign stall_cycles    = stall_cycles_q;
    assign flush_count     = flush_count_q;

endmodule : pipe_ctrl
`default_nettype wire
